// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the load/store controller.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_t;

  // Misaligned or illegal-size request; such requests never reach memory.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = lo[0];
      SZ_WORD: req_bad = (lo != 2'b00);
      default: req_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
module mem_lane_unit
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = old_word[{lane, 3'b000} +: 8];
  assign half_sel = old_word[{lane[1], 4'b0000} +: 16];

  // Pick the addressed lane and sign- or zero-extend it.
  always_comb begin
    load_data = old_word;
    case (size)
      SZ_BYTE: load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sgn & half_sel[15]}}, half_sel};
      default: load_data = old_word;
    endcase
  end

  // Overlay the low byte/half of the store data onto the addressed lane.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8]     = new_data[7:0];
      SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Single-outstanding load/store controller in front of a 1 KiB word-wide memory.
// Sub-word stores do a read-modify-write since the memory always writes 4 bytes.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  input  logic [DATA_W-1:0] mem_rddata
);

  state_t            state, state_nxt;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       wword;     // store data, later the merged write word
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              bad;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign accept = req_valid & req_ready;
  assign bad    = req_bad(req_size, req_addr[1:0]);

  // Gated by rst_n so the handshake is closed for the whole reset pulse.
  assign req_ready  = (state == IDLE) & rst_n;
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Memory strobes come from the state register only.
  assign mem_read   = (state == RD) | (state == RMW_RD);
  assign mem_write  = (state == WR);
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wrdata = mem_write ? wword : '0;

  mem_lane_unit u_lane (
    .size      (r_size),
    .lane      (r_addr[1:0]),
    .sgn       (r_signed),
    .old_word  (mem_rddata),
    .new_data  (wword),
    .load_data (load_data),
    .merged    (merged)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (bad)                   state_nxt = RESP;
        else if (!req_we)          state_nxt = RD;
        else if (req_size == SZ_WORD) state_nxt = WR;
        else                       state_nxt = RMW_RD;
      end
      RD:      state_nxt = RESP;
      RMW_RD:  state_nxt = WR;
      WR:      state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, load result and RMW write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      wword    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          r_size   <= req_size;
          r_signed <= req_signed;
          r_addr   <= req_addr;
          wword    <= req_wdata;
          rdata_q  <= '0;
          err_q    <= bad;
        end
        RD:      rdata_q <= load_data;
        RMW_RD:  wword   <= merged;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 1 KiB word memory.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_signed, resp_ready;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid, resp_err, mem_write, mem_read;
  logic [31:0] resp_rdata, mem_wrdata, mem_rddata;
  logic [9:0]  mem_addr;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  // Results of the last transaction
  int          lat, nrd, nwr;
  logic        order_bad, got;
  logic [31:0] rd_res, wr_seen;
  logic [9:0]  addr_seen;
  logic        err_res;

  always #5 clk = ~clk;

  assign mem_rddata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wrdata;

  mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_write(mem_write),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
    .mem_rddata(mem_rddata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to its response (bounded), recording
  // latency, strobe counts and what the memory port showed.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [9:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; order_bad = 1'b0; wr_seen = '0; addr_seen = '0;
    while (!resp_valid && lat < 20) begin
      if (mem_read)  begin nrd++; if (nwr != 0) order_bad = 1'b1; end
      if (mem_write) begin nwr++; wr_seen = mem_wrdata; end
      if (mem_read || mem_write) addr_seen = mem_addr;
      @(posedge clk); #1;
      lat++;
    end
    got = resp_valid; rd_res = resp_rdata; err_res = resp_err;
    if (!got) begin
      errors++;
      $display("FAIL timeout: no response to request @%h", a);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    #3;
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst mem_addr", {22'd0, mem_addr}, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("idle req_ready", {31'd0, req_ready}, 32'd1);

    // sw / lw round trip
    do_req(1, 2'b10, 0, 10'h010, 32'hDEADBEEF);
    chk("sw lat", lat, 2);
    chk("sw wrdata", wr_seen, 32'hDEADBEEF);
    chk("sw rdata", rd_res, 32'd0);
    chk("sw nrd", nrd, 0);
    do_req(0, 2'b10, 0, 10'h010, 32'h0);
    chk("lw lat", lat, 2);
    chk("lw rdata", rd_res, 32'hDEADBEEF);
    chk("lw err", {31'd0, err_res}, 32'd0);

    // byte store RMW
    do_req(1, 2'b00, 0, 10'h012, 32'hFFFFFF5A);
    chk("sb lat", lat, 3);
    chk("sb nrd", nrd, 1);
    chk("sb nwr", nwr, 1);
    chk("sb order", {31'd0, order_bad}, 32'd0);
    chk("sb wrdata", wr_seen, 32'hDE5ABEEF);
    do_req(0, 2'b10, 0, 10'h010, 32'h0);
    chk("sb readback", rd_res, 32'hDE5ABEEF);

    // signed / unsigned loads
    do_req(1, 2'b10, 0, 10'h020, 32'h80FF7F01);
    do_req(0, 2'b00, 1, 10'h021, 32'h0);
    chk("lb 021", rd_res, 32'h0000007F);
    do_req(0, 2'b00, 1, 10'h023, 32'h0);
    chk("lb 023", rd_res, 32'hFFFFFF80);
    do_req(0, 2'b01, 0, 10'h022, 32'h0);
    chk("lhu 022", rd_res, 32'h000080FF);
    do_req(0, 2'b01, 1, 10'h022, 32'h0);
    chk("lh 022", rd_res, 32'hFFFF80FF);
    do_req(0, 2'b00, 0, 10'h023, 32'h0);
    chk("lbu 023", rd_res, 32'h00000080);

    // half store RMW on upper lane
    do_req(1, 2'b01, 0, 10'h022, 32'hAAAA1234);
    chk("sh wrdata", wr_seen, 32'h12347F01);

    // errors
    do_req(0, 2'b10, 0, 10'h011, 32'h0);
    chk("lw mis err", {31'd0, err_res}, 32'd1);
    chk("lw mis lat", lat, 1);
    chk("lw mis strobes", nrd + nwr, 0);
    chk("lw mis rdata", rd_res, 32'd0);
    do_req(1, 2'b01, 0, 10'h3FF, 32'h1111);
    chk("sh mis err", {31'd0, err_res}, 32'd1);
    chk("sh mis lat", lat, 1);
    chk("sh mis strobes", nrd + nwr, 0);
    do_req(0, 2'b11, 0, 10'h000, 32'h0);
    chk("sz11 err", {31'd0, err_res}, 32'd1);
    chk("sz11 lat", lat, 1);
    chk("sz11 strobes", nrd + nwr, 0);
    chk("sz11 rdata", rd_res, 32'd0);

    // top address
    do_req(1, 2'b10, 0, 10'h3FC, 32'h12345678);
    chk("top sw addr", {22'd0, addr_seen}, 32'h3FC);
    do_req(0, 2'b00, 0, 10'h3FF, 32'h0);
    chk("top lbu", rd_res, 32'h00000012);
    chk("top lbu addr", {22'd0, addr_seen}, 32'h3FC);

    // backpressure: response held while resp_ready low
    resp_ready = 1'b0;
    do_req(0, 2'b10, 0, 10'h010, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp rdata", resp_rdata, 32'hDE5ABEEF);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp drained", {30'd0, resp_valid, req_ready}, 32'd1);

    // reset during WR leaves memory untouched
    do_req(1, 2'b10, 0, 10'h040, 32'h11111111);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 10'h040;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wr before rst", {31'd0, mem_write}, 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("rst mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst req_ready2", {31'd0, req_ready}, 32'd0);
    chk("rst resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst addr2", {22'd0, mem_addr}, 32'd0);
    chk("rst wrdata", mem_wrdata, 32'd0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    do_req(0, 2'b10, 0, 10'h040, 32'h0);
    chk("post rst lw", rd_res, 32'h11111111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
